ex_mem_pipe_stage: RTL
======================

Name: ex_mem_pipe_stage

Overview:
- Parametrised EX->MEM pipeline boundary register for the CPU datapath.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure from the memory stage, and a synchronous flush for branch/exception squash.
- Control bits become architecturally inert on bubbles.
- Includes a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 16, width of ALU result and store data.
- ADDR_W, 4, width of destination register address.
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all buffered and incoming beats this cycle.
- in_valid  in  1  EX stage presents a beat.
- in_ready  out  1  stage can accept a beat. Registered.
- MemWriteE  in  1  store enable.
- MemToRegE  in  1  writeback source select.
- RegWriteE  in  1  register-file write enable.
- destAddE  in  ADDR_W  destination register.
- alu_resultE  in  DATA_W  ALU result / memory address.
- store_dataE  in  DATA_W  store data.
- out_valid  out  1  MEM stage beat valid.
- out_ready  in  1  MEM stage consumes beat.
- MemWriteM  out  1  gated store enable.
- MemToRegM  out  1  writeback select.
- RegWriteM  out  1  gated write enable.
- destAddM  out  ADDR_W  destination register.
- alu_resultM  out  DATA_W  ALU result.
- store_dataM  out  DATA_W  store data.
- occupancy  out  2  entries held, 0..2.
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0. Saturates.

Behaviour:
- Handshakes:
  - accept = in_valid & in_ready.
  - take = out_valid & out_ready.
- Storage:
  - main entry drives the outputs.
  - skid entry holds overflow.
  - each entry has a valid bit.
- States, encoded by occupancy:
  - EMPTY(0):
    - accept -> ONE, main loaded.
    - no accept -> stay EMPTY.
  - ONE(1):
    - accept & take -> ONE, main reloaded with the new beat.
    - accept & !take -> TWO, new beat stored in skid.
    - !accept & take -> EMPTY.
    - else hold.
  - TWO(2):
    - in_ready=0, so no accept is possible.
    - take -> ONE, skid moves to main.
    - else hold.
- in_ready is registered and equals (next occupancy < 2). No combinational path from out_ready to in_ready.
- Latency:
  - 1 cycle from an accepting edge to out_valid when EMPTY.
  - Throughput is 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO. A skid beat is never bypassed by a new beat.
- Gating:
  - MemWriteM = main.MemWrite & out_valid.
  - RegWriteM = main.RegWrite & out_valid.
  - The other data outputs hold their last value when invalid.
- flush:
  - On the next edge, both valid bits are cleared and occupancy = 0; in_ready = 1 next cycle.
  - A beat offered in the flush cycle is discarded.
  - A take in the flush cycle is still consumed by MEM (the current beat was already seen).
- reset:
  - Highest priority, above flush.
  - On the edge with reset=1, all outputs clear to 0 (including data, occupancy and stall_count) and in_ready = 1.
  - Any buffered beats mid-operation are lost.
- stall_count:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Widths: no arithmetic on the datapath. Fields are copied bit-exact.

Test Plan:
- Reset:
  - Stimulus: drive garbage inputs with reset=1 for 2 cycles, then release.
  - Required: all outputs 0, in_ready=1, occupancy=0.
- Single beat:
  - Stimulus: in_valid=1 for 1 cycle with alu_resultE=16'h1234, destAddE=4'h5, RegWriteE=1, MemWriteE=0; out_ready=1.
  - Required:
    - next cycle: out_valid=1, alu_resultM=16'h1234, destAddM=5, RegWriteM=1.
    - cycle after: out_valid=0, RegWriteM=0.
- Back-pressure:
  - Stimulus: out_ready=0; stream beats A=16'h0001, B=16'h0002, C=16'h0003 with in_valid=1; then release out_ready.
  - Required:
    - A and B accepted; occupancy=2; in_ready=0; C is held by EX.
    - After release, outputs in order A, B, C on consecutive cycles.
    - stall_count equals the number of stalled cycles.
- Streaming:
  - Stimulus: 8 beats 0..7 back-to-back with out_ready=1.
  - Required: 8 consecutive out_valid cycles; values 0..7 in order; occupancy never exceeds 1.
- Flush with full buffer:
  - Stimulus: occupancy=2 with MemWriteE=1 beats; assert flush with in_valid=1 and a new beat 16'hDEAD.
  - Required:
    - next cycle: out_valid=0, MemWriteM=0, occupancy=0, in_ready=1.
    - 16'hDEAD never appears on the outputs.
- Saturation:
  - Stimulus: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline boundary register.
// The stage has a valid/ready handshake and a two-entry skid buffer. in_ready
// comes straight from a flop, so the MEM stage's out_ready never reaches
// upstream through combinational logic.
// A flush squashes every buffered beat. It also drops any beat offered in the
// same cycle.
// Store and writeback enables read as 0 whenever no beat is presented.
// A saturating counter records how many cycles the MEM stage stalled a valid
// beat.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MemWriteE,
  input  logic              MemToRegE,
  input  logic              RegWriteE,
  input  logic [ADDR_W-1:0] destAddE,
  input  logic [DATA_W-1:0] alu_resultE,
  input  logic [DATA_W-1:0] store_dataE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              MemWriteM,
  output logic              MemToRegM,
  output logic              RegWriteM,
  output logic [ADDR_W-1:0] destAddM,
  output logic [DATA_W-1:0] alu_resultM,
  output logic [DATA_W-1:0] store_dataM,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // A beat is {MemWrite, MemToReg, RegWrite, destAdd, alu_result, store_data}.
  localparam int ENT_W = 3 + ADDR_W + 2 * DATA_W;

  logic [ENT_W-1:0] inBeat;
  logic [ENT_W-1:0] mainBeat_p0;
  logic [ENT_W-1:0] skidBeat_p1;
  logic             mainVld_p0;
  logic             skidVld_p1;
  logic             inReady;
  logic [CNT_W-1:0] stallCnt;

  logic             accept;
  logic             take;
  logic [1:0]       occNow;
  logic [1:0]       occNext;

  logic             mainMemWrite;
  logic             mainRegWrite;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign inBeat = {MemWriteE, MemToRegE, RegWriteE, destAddE, alu_resultE, store_dataE};

  // Handshake terms and occupancy bookkeeping. The skid entry is only ever
  // valid while the main entry is valid.
  always_comb begin
    accept  = in_valid & inReady;
    take    = mainVld_p0 & out_ready;
    occNow  = {skidVld_p1, mainVld_p0 & ~skidVld_p1};
    occNext = occNow + {1'b0, accept} - {1'b0, take};
  end

  // Control state: entry valid bits, registered in_ready and the stall counter.
  // Reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainVld_p0 <= 1'b0;
      skidVld_p1 <= 1'b0;
      inReady    <= 1'b1;
      stallCnt   <= '0;
    end else begin
      if (mainVld_p0 && !out_ready) stallCnt <= satInc(stallCnt);
      if (flush) begin
        mainVld_p0 <= 1'b0;
        skidVld_p1 <= 1'b0;
        inReady    <= 1'b1;
      end else begin
        inReady <= (occNext < 2'd2);
        if (take) begin
          if (skidVld_p1)   skidVld_p1 <= 1'b0;
          else if (!accept) mainVld_p0 <= 1'b0;
        end else if (accept) begin
          if (mainVld_p0) skidVld_p1 <= 1'b1;
          else            mainVld_p0 <= 1'b1;
        end
      end
    end
  end

  // Main entry payload, which drives the MEM-side outputs. It clears on reset
  // so the outputs read as 0. On a take it refills from skid first, which
  // keeps beats in FIFO order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainBeat_p0 <= '0;
    end else if (!flush) begin
      if (take && skidVld_p1)                 mainBeat_p0 <= skidBeat_p1;
      else if (accept && (take || !mainVld_p0)) mainBeat_p0 <= inBeat;
    end
  end

  // Skid entry payload. It captures a new beat only when main is occupied
  // and not draining this cycle.
  always_ff @(posedge clk) begin
    if (!flush && accept && mainVld_p0 && !take) skidBeat_p1 <= inBeat;
  end

  assign {mainMemWrite, MemToRegM, mainRegWrite, destAddM, alu_resultM, store_dataM} = mainBeat_p0;

  assign out_valid   = mainVld_p0;
  assign MemWriteM   = mainMemWrite & mainVld_p0;
  assign RegWriteM   = mainRegWrite & mainVld_p0;
  assign in_ready    = inReady;
  assign occupancy   = occNow;
  assign stall_count = stallCnt;

endmodule
